// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, requester ids, counter width.
package mem_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  // Wide enough for the largest supported latency (15).
  localparam int CNT_W = 4;

  function automatic logic misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch and data requesters; on a collision the requester
// that was not granted last wins.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic    i_req,
  input  logic    d_req,
  input  req_id_t last,
  output logic    i_pick,
  output logic    d_pick
);

  always_comb begin
    i_pick = 1'b0;
    d_pick = 1'b0;
    if (i_req && d_req) begin
      if (last == REQ_I) d_pick = 1'b1;
      else               i_pick = 1'b1;
    end else if (d_req) begin
      d_pick = 1'b1;
    end else if (i_req) begin
      i_pick = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port memory with fixed read latency.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [AWIDTH-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DWIDTH-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DWIDTH-1:0] d_rdata,
  output logic              d_err,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_read_en,
  output logic              mem_write_en,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LAT - 1);

  arb_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  req_id_t           last;
  req_id_t           owner;
  logic [DWIDTH-1:0] rdata_q;
  logic              err_q;
  logic              i_pick, d_pick;
  logic              done, can_grant, gnt_any, mis;

  assign done      = (state == ARB_WAIT) && (cnt == '0);
  assign can_grant = (state == ARB_IDLE) || done;
  assign i_gnt     = can_grant && i_pick;
  assign d_gnt     = can_grant && d_pick;
  assign gnt_any   = i_gnt || d_gnt;
  assign mis       = d_gnt ? misaligned(d_addr[1:0]) : misaligned(i_addr[1:0]);

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      last <= REQ_I;
    else if (i_gnt) last <= REQ_I;
    else if (d_gnt) last <= REQ_D;
  end
`else
  // Pretending fetch always went last gives data fixed priority.
  assign last = REQ_I;
`endif

  mem_arb_pick u_pick (
    .i_req  (i_req),
    .d_req  (d_req),
    .last   (last),
    .i_pick (i_pick),
    .d_pick (d_pick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ARB_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ARB_IDLE: begin
        if (gnt_any) begin
          state_nxt = ARB_WAIT;
          cnt_nxt   = LAT_M1;
        end
      end
      ARB_WAIT: begin
        if (gnt_any)         cnt_nxt   = LAT_M1;
        else if (cnt == '0)  state_nxt = ARB_IDLE;
        else                 cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    if (d_gnt) begin
      mem_addr     = d_addr;
      mem_wdata    = d_we ? d_wdata : '0;
      mem_read_en  = !d_we && !mis;
      mem_write_en = d_we && !mis;
    end else if (i_gnt) begin
      mem_addr    = i_addr;
      mem_read_en = !mis;
    end
    busy     = (state == ARB_WAIT);
    i_rvalid = done && (owner == REQ_I);
    d_rvalid = done && (owner == REQ_D);
    i_rdata  = i_rvalid ? rdata_q : '0;
    d_rdata  = d_rvalid ? rdata_q : '0;
    i_err    = i_rvalid && err_q;
    d_err    = d_rvalid && err_q;
  end

  // Memory data is only valid in the grant cycle, so it is captured there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner   <= REQ_I;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (gnt_any) begin
      owner   <= d_gnt ? REQ_D : REQ_I;
      rdata_q <= mem_read_en ? mem_rdata : '0;
      err_q   <= mis;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one LAT=1 and one LAT=3 instance on shared stimulus.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;

  logic        i_gnt_1, i_rvalid_1, i_err_1, d_gnt_1, d_rvalid_1, d_err_1;
  logic        mem_read_en_1, mem_write_en_1, busy_1;
  logic [31:0] i_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;

  logic        i_gnt_3, i_rvalid_3, i_err_3, d_gnt_3, d_rvalid_3, d_err_3;
  logic        mem_read_en_3, mem_write_en_3, busy_3;
  logic [31:0] i_rdata_3, d_rdata_3, mem_addr_3, mem_wdata_3, mem_rdata_3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h0100_0000) ? 32'h0000_0013 : (a ^ 32'h5A5A_0000);
  endfunction

  assign mem_rdata_1 = mem_model(mem_addr_1);
  assign mem_rdata_3 = mem_model(mem_addr_3);

  mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .LAT(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_1), .i_rvalid(i_rvalid_1),
    .i_rdata(i_rdata_1), .i_err(i_err_1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt_1),
    .d_rvalid(d_rvalid_1), .d_rdata(d_rdata_1), .d_err(d_err_1),
    .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .mem_read_en(mem_read_en_1),
    .mem_write_en(mem_write_en_1), .mem_rdata(mem_rdata_1), .busy(busy_1)
  );

  mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .LAT(3)) dut_l3 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_3), .i_rvalid(i_rvalid_3),
    .i_rdata(i_rdata_3), .i_err(i_err_3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt_3),
    .d_rvalid(d_rvalid_3), .d_rdata(d_rdata_3), .d_err(d_err_3),
    .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3), .mem_read_en(mem_read_en_3),
    .mem_write_en(mem_write_en_3), .mem_rdata(mem_rdata_3), .busy(busy_3)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_d;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy1",  32'(busy_1), 32'd0);
    chk("rst_rd1",    32'(mem_read_en_1), 32'd0);
    chk("rst_addr1",  mem_addr_1, 32'd0);
    chk("rst_ival3",  32'(i_rvalid_3), 32'd0);
    chk("rst_busy3",  32'(busy_3), 32'd0);
    reset = 1'b0;

    // lone fetch
    drive_point();
    i_req = 1'b1; i_addr = 32'h0100_0000;
    @(negedge clk);
    chk("f_ignt",  32'(i_gnt_1), 32'd1);
    chk("f_dgnt",  32'(d_gnt_1), 32'd0);
    chk("f_rd",    32'(mem_read_en_1), 32'd1);
    chk("f_addr",  mem_addr_1, 32'h0100_0000);
    drive_point();
    i_req = 1'b0; i_addr = '0;
    @(negedge clk);
    chk("f_ival",  32'(i_rvalid_1), 32'd1);
    chk("f_idata", i_rdata_1, 32'h0000_0013);
    chk("f_ierr",  32'(i_err_1), 32'd0);
    chk("f_busy",  32'(busy_1), 32'd1);
    drive_point();
    @(negedge clk);
    chk("f_ival_off", 32'(i_rvalid_1), 32'd0);
    chk("f_idle",     32'(busy_1), 32'd0);
    repeat (4) @(posedge clk);

    // simultaneous fetch and data read
    #1;
    i_req = 1'b1; i_addr = 32'h0100_0000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_0010;
    @(negedge clk);
    chk("s_dgnt",  32'(d_gnt_1), 32'd1);
    chk("s_ignt",  32'(i_gnt_1), 32'd0);
    chk("s_addr",  mem_addr_1, 32'h0100_0010);
    chk("s_rd",    32'(mem_read_en_1), 32'd1);
    drive_point();
    d_req = 1'b0;
    @(negedge clk);
    chk("s_dval",  32'(d_rvalid_1), 32'd1);
    chk("s_ddata", d_rdata_1, 32'h5B5A_0010);
    chk("s_ignt2", 32'(i_gnt_1), 32'd1);
    chk("s_dgnt2", 32'(d_gnt_1), 32'd0);
    chk("s_addr2", mem_addr_1, 32'h0100_0000);
    drive_point();
    i_req = 1'b0;
    @(negedge clk);
    chk("s_ival",  32'(i_rvalid_1), 32'd1);
    chk("s_idata", i_rdata_1, 32'h0000_0013);
    chk("s_dval0", 32'(d_rvalid_1), 32'd0);
    repeat (4) @(posedge clk);

    // both requesting continuously for six grants
    #1;
    i_req = 1'b1; i_addr = 32'h0100_0000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_0010;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
`ifdef MEM_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      chk("c_dgnt", 32'(d_gnt_1), 32'(exp_d));
      chk("c_ignt", 32'(i_gnt_1), 32'(!exp_d));
      chk("c_both", 32'(i_gnt_1 & d_gnt_1), 32'd0);
      drive_point();
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (4) @(posedge clk);

    // data store
    #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0100_0004; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("w_dgnt",  32'(d_gnt_1), 32'd1);
    chk("w_wr",    32'(mem_write_en_1), 32'd1);
    chk("w_rd",    32'(mem_read_en_1), 32'd0);
    chk("w_wdata", mem_wdata_1, 32'hDEAD_BEEF);
    chk("w_addr",  mem_addr_1, 32'h0100_0004);
    drive_point();
    d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    @(negedge clk);
    chk("w_wr_off", 32'(mem_write_en_1), 32'd0);
    chk("w_dval",   32'(d_rvalid_1), 32'd1);
    chk("w_ddata",  d_rdata_1, 32'd0);
    chk("w_derr",   32'(d_err_1), 32'd0);

    // misaligned data read
    drive_point();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_0002;
    @(negedge clk);
    chk("m_dgnt", 32'(d_gnt_1), 32'd1);
    chk("m_rd",   32'(mem_read_en_1), 32'd0);
    chk("m_wr",   32'(mem_write_en_1), 32'd0);
    drive_point();
    d_req = 1'b0; d_addr = '0;
    @(negedge clk);
    chk("m_dval",  32'(d_rvalid_1), 32'd1);
    chk("m_derr",  32'(d_err_1), 32'd1);
    chk("m_ddata", d_rdata_1, 32'd0);
    repeat (5) @(posedge clk);

    // reset one cycle after a grant on the LAT=3 instance
    #1;
    i_req = 1'b1; i_addr = 32'h0100_0000;
    @(negedge clk);
    chk("r_ignt", 32'(i_gnt_3), 32'd1);
    drive_point();
    i_req = 1'b0; i_addr = '0;
    @(negedge clk);
    chk("r_busy", 32'(busy_3), 32'd1);
    reset = 1'b1;
    #1;
    chk("r_busy0", 32'(busy_3), 32'd0);
    chk("r_ival0", 32'(i_rvalid_3), 32'd0);
    chk("r_rd0",   32'(mem_read_en_3), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("r_no_ival", 32'(i_rvalid_3), 32'd0);
      chk("r_no_dval", 32'(d_rvalid_3), 32'd0);
    end
    drive_point();
    i_req = 1'b1; i_addr = 32'h0100_0000;
    @(negedge clk);
    chk("r2_ignt", 32'(i_gnt_3), 32'd1);
    drive_point();
    i_req = 1'b0; i_addr = '0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("r2_ival", 32'(i_rvalid_3), 32'(k == 3));
      if (k == 3) chk("r2_idata", i_rdata_3, 32'h0000_0013);
      if (k < 3) drive_point();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
